// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared types and constants for the I2C LUT sequencer
// Holds the sequencer state encoding, the bit positions of the fields packed
// into each 32-bit LUT entry, and the default delay and end-of-table markers.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    GAP,
    DELAY,
    NEXT,
    DONE,
    ERROR
  } state_t;

  // LUT entry layout: {dev_addr, reg_addr, reg_data}
  localparam int DEV_MSB = 31;
  localparam int DEV_LSB = 24;
  localparam int REG_MSB = 23;
  localparam int REG_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;

  localparam logic [7:0]  DEF_DELAY_DEV = 8'hFE;
  localparam logic [31:0] DEF_END_WORD  = 32'hFFFF_FFFF;

endpackage

// File: rtl/i2c_seq_timer.sv
// rtl/i2c_seq_timer.sv - loadable down-counter with zero flag for GAP/DELAY waits
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   zero      : counter currently holds zero
// The counter decrements every cycle until it reaches zero and then holds.
module i2c_seq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_lut_sequencer.sv
// rtl/i2c_lut_sequencer.sv - walks a register LUT and issues one I2C write per entry
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   start                      : 1-cycle pulse, begins a walk from index 0 (only in IDLE)
//   lut_index / lut_data       : combinational LUT address / entry {dev, reg, data}
//   i2c_req, i2c_dev_addr,
//   i2c_reg_addr, i2c_reg_data : write request and fields to the I2C master
//   i2c_ack, i2c_nack          : transaction finished / slave NACKed (valid with ack)
//   busy, done, error          : walk status; done and error are sticky until next start
//   err_index                  : index of the failing entry when error=1
module i2c_lut_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int          LUT_AW     = 10,
  parameter int          MAX_RETRY  = 3,
  parameter int          RETRY_GAP  = 1000,
  parameter int          DELAY_UNIT = 50000,
  parameter logic [7:0]  DELAY_DEV  = DEF_DELAY_DEV,
  parameter logic [31:0] END_WORD   = DEF_END_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [LUT_AW-1:0] lut_index,
  input  logic [31:0]       lut_data,
  output logic              i2c_req,
  output logic [7:0]        i2c_dev_addr,
  output logic [15:0]       i2c_reg_addr,
  output logic [7:0]        i2c_reg_data,
  input  logic              i2c_ack,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LUT_AW-1:0] err_index
);

  localparam int RC_W = $clog2(MAX_RETRY + 2);
  // The timer is loaded with N-1 on the entry edge so the wait state lasts N cycles.
  localparam logic [31:0] GAP_LOAD = (RETRY_GAP > 0) ? 32'(RETRY_GAP - 1) : 32'd0;

  state_t          state;
  logic [RC_W-1:0] retry_cnt;
  logic            timer_load;
  logic [31:0]     timer_val;
  logic            timer_zero;
  logic [31:0]     delay_cycles;
  logic            is_end;
  logic            is_delay;

  assign is_end       = (lut_data == END_WORD);
  assign is_delay     = (lut_data[DEV_MSB:DEV_LSB] == DELAY_DEV);
  assign delay_cycles = 32'(lut_data[DAT_MSB:DAT_LSB]) * 32'(DELAY_UNIT);

  // Timer is loaded on the edge that enters DELAY or GAP.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (state == FETCH && !is_end && is_delay) begin
      timer_load = 1'b1;
      timer_val  = delay_cycles - 32'd1;
    end else if (state == ISSUE && i2c_ack && i2c_nack) begin
      timer_load = 1'b1;
      timer_val  = GAP_LOAD;
    end
  end

  i2c_seq_timer #(.W(32)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lut_index    <= '0;
      retry_cnt    <= '0;
      i2c_req      <= 1'b0;
      i2c_dev_addr <= '0;
      i2c_reg_addr <= '0;
      i2c_reg_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_index    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            lut_index <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (is_end) begin
            state <= DONE;
          end else if (is_delay) begin
            // A zero-length delay skips the wait entirely.
            state <= (lut_data[DAT_MSB:DAT_LSB] == 8'd0) ? NEXT : DELAY;
          end else begin
            i2c_dev_addr <= lut_data[DEV_MSB:DEV_LSB];
            i2c_reg_addr <= lut_data[REG_MSB:REG_LSB];
            i2c_reg_data <= lut_data[DAT_MSB:DAT_LSB];
            i2c_req      <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (i2c_ack) begin
            i2c_req <= 1'b0;
            if (!i2c_nack) begin
              state <= NEXT;
            end else if (retry_cnt < RC_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= GAP;
            end else begin
              state <= ERROR;
            end
          end
        end
        GAP: begin
          // Re-issue uses the fields still latched on the i2c_* outputs.
          if (timer_zero) begin
            i2c_req <= 1'b1;
            state   <= ISSUE;
          end
        end
        DELAY: begin
          if (timer_zero) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          retry_cnt <= '0;
          if (lut_index == '1) begin
            state <= DONE;
          end else begin
            lut_index <= lut_index + 1'b1;
            state     <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERROR: begin
          error     <= 1'b1;
          err_index <= lut_index;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_lut_sequencer.md
Name: i2c_lut_sequencer

Overview:
- Walks a camera register look-up table and issues one I2C register-write per entry to a byte-level I2C write master through a req/ack handshake.
- Adds three features to plain table walking: NACK retry, delay entries for sensor power-up and PLL settle, and an end-of-table marker.
- Sits between the sensor LUT and the shared I2C master in the camera config path. Reports busy, done and error status to the system.

Parameters:
- LUT_AW, 10, LUT index width; the table has at most 2^LUT_AW entries.
- MAX_RETRY, 3, number of re-issues after a NACK before the sequencer aborts.
- RETRY_GAP, 1000, idle clk cycles between a NACK and the re-issue.
- DELAY_UNIT, 50000, clk cycles per delay count (1 ms at 50 MHz).
- DELAY_DEV, 8'hFE, value of lut_data[31:24] that marks a delay entry.
- END_WORD, 32'hFFFF_FFFF, lut_data value that marks end of table.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a table walk from index 0. Ignored while busy.
- lut_index  out  LUT_AW  current table address. The LUT is combinational.
- lut_data  in  32  {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]}.
- i2c_req  out  1  write request to the I2C master; held high until i2c_ack.
- i2c_dev_addr  out  8  device address, registered from the entry.
- i2c_reg_addr  out  16  register address, registered from the entry.
- i2c_reg_data  out  8  register data, registered from the entry.
- i2c_ack  in  1  1-cycle pulse from the I2C master: transaction finished.
- i2c_nack  in  1  sampled only when i2c_ack=1; 1 means the slave NACKed.
- busy  out  1  high from the cycle after start until DONE or ERROR is entered.
- done  out  1  sticky; the table completed without error.
- error  out  1  sticky; retries were exhausted.
- err_index  out  LUT_AW  index of the entry that failed; valid when error=1.

Behaviour:
Reset
- Reset values: state=IDLE; all outputs 0; lut_index=0.
- Reset asserted mid-transaction drops i2c_req immediately.
- Any late i2c_ack arriving in IDLE is ignored.

States
- IDLE:
  - start -> FETCH; lut_index<=0; retry_cnt<=0; done<=0; error<=0; busy<=1.
- FETCH (1 cycle, LUT settle). Decode lut_data:
  - lut_data==END_WORD -> DONE.
  - dev_addr==DELAY_DEV -> DELAY; load the cycle counter with reg_data*DELAY_UNIT (32-bit product, no overflow). reg_data=0 passes straight to NEXT.
  - Otherwise -> ISSUE; register dev/reg/data onto the i2c_* outputs; i2c_req<=1.
- ISSUE: i2c_req held high until i2c_ack.
  - ack & !nack -> NEXT; i2c_req<=0 in the same cycle.
  - ack & nack, retry_cnt<MAX_RETRY -> GAP; retry_cnt++.
  - ack & nack, retry_cnt==MAX_RETRY -> ERROR.
  - i2c_* outputs stay stable while i2c_req=1.
- GAP: counts RETRY_GAP cycles -> ISSUE with the same latched entry; i2c_req<=1.
- DELAY: counts down to 1 -> NEXT.
- NEXT: retry_cnt<=0.
  - lut_index == 2^LUT_AW-1 -> DONE (index wrap treated as end of table).
  - Otherwise lut_index++ -> FETCH.
- DONE: done<=1; busy<=0 -> IDLE.
- ERROR: error<=1; err_index<=lut_index; busy<=0 -> IDLE.
- done and error persist until the next accepted start.

Timing and edge cases
- Latency, start to first i2c_req: 2 cycles (IDLE->FETCH, FETCH->ISSUE).
- Per-entry overhead excluding I2C time: 3 cycles (ISSUE exit, NEXT, FETCH).
- start coinciding with DONE/ERROR is ignored. It is accepted only once the state is IDLE.
- i2c_ack outside ISSUE is ignored.
- Simultaneous i2c_ack and the req drop are legal; the master must sample req only when idle.
- MAX_RETRY=0: the first NACK goes to ERROR.

Decomposition:
- Package i2c_cfg_pkg holds:
  - state enum (IDLE, FETCH, ISSUE, GAP, DELAY, NEXT, DONE, ERROR);
  - LUT field slice constants (DEV_MSB/LSB, REG_MSB/LSB, DAT_MSB/LSB);
  - default DELAY_DEV and END_WORD.
- One sub-module: i2c_seq_timer, a loadable down-counter with a zero flag, shared by the GAP and DELAY waits.

Test Plan:
- Three-entry table {0x78_3008_82, 0x78_3103_02, END_WORD}; the I2C model acks each after 20 cycles -> exactly 2 i2c_req handshakes with matching fields, then done=1, busy=0, error=0.
- Entry 1 NACKed twice then acked, MAX_RETRY=3 -> entry 1 is issued 3 times; consecutive issues are spaced ≥ RETRY_GAP cycles apart; done=1.
- Entry 2 always NACKed, MAX_RETRY=3 -> 4 issues, then error=1, err_index=2, done=0, no further req.
- Delay entry {0xFE_0000_05}, DELAY_UNIT=10 -> next i2c_req rises ≥50 cycles after the delay entry's FETCH; a reg_data=0 delay adds no wait.
- rst pulsed while i2c_req=1 -> req drops asynchronously and all outputs return to 0. A subsequent start restarts from index 0.
- start pulsed again while busy -> ignored; lut_index sequence unaffected. start pulsed after done -> done clears and the walk repeats.
